// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset release sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_DELAY    = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_DONE     = 2'd2
    } seq_state_t;

    // One counter serves both the settle delay and the ready timeout.
    function automatic int cnt_width(input int delay, input int timeout);
        int m;
        m = (delay > timeout) ? delay : timeout;
        return $clog2(m + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_release_sequencer_if.sv
// Bundle between the sequencer and the subsystems whose resets it releases.
interface rst_release_sequencer_if
    import rst_seq_pkg::*;
#(
    parameter int STAGES = 4
);
    localparam int STAGE_W = idx_width(STAGES);

    logic               sw_rst_i;
    logic [STAGES-1:0]  stage_ready_i;
    logic [STAGES-1:0]  rst_o;
    logic [STAGE_W-1:0] stage_o;
    logic               done_o;
    logic               timeout_o;

    modport master (
        input  sw_rst_i,
        input  stage_ready_i,
        output rst_o,
        output stage_o,
        output done_o,
        output timeout_o
    );

    modport slave (
        output sw_rst_i,
        output stage_ready_i,
        input  rst_o,
        input  stage_o,
        input  done_o,
        input  timeout_o
    );

endinterface

// File: rtl/rst_release_sequencer.sv
// Releases STAGES subsystem resets in index order, each after a settle delay
// and gated on the previous stage's ready (with a timeout fallback).
module rst_release_sequencer
    import rst_seq_pkg::*;
#(
    parameter int   STAGES  = 4,
    parameter int   DELAY   = 16,
    parameter int   TIMEOUT = 1024,
    parameter logic OUT_POL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n_i,
    rst_release_sequencer_if.master bus
);

    localparam int STAGE_W = idx_width(STAGES);
    localparam int CNT_W   = cnt_width(DELAY, TIMEOUT);

    seq_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [STAGE_W-1:0] stage_reg, stage_next;
    logic [STAGES-1:0]  rst_reg, rst_next;
    logic               done_reg, done_next;
    logic               timeout_reg, timeout_next;

    logic [STAGES-1:0]  stage_hit;
    logic               ready_sel;
    logic               delay_hit;
    logic               timeout_hit;
    logic               last_stage;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            assign stage_hit[gi] = (stage_reg == STAGE_W'(gi));
        end
    endgenerate

    // Only the stage currently being sequenced can end a ready wait.
    assign ready_sel   = |(stage_hit & bus.stage_ready_i);
    assign delay_hit   = (cnt_reg == CNT_W'(DELAY - 1));
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
    assign last_stage  = (stage_reg == STAGE_W'(STAGES - 1));

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        stage_next   = stage_reg;
        rst_next     = rst_reg;
        done_next    = done_reg;
        timeout_next = timeout_reg;

        if (bus.sw_rst_i) begin
            state_next   = ST_DELAY;
            cnt_next     = '0;
            stage_next   = '0;
            rst_next     = {STAGES{OUT_POL}};
            done_next    = 1'b0;
            timeout_next = 1'b0;
        end else begin
            case (state_reg)
                ST_DELAY: begin
                    if (delay_hit) begin
                        rst_next   = OUT_POL ? (rst_reg & ~stage_hit) : (rst_reg | stage_hit);
                        cnt_next   = '0;
                        state_next = ST_WAIT_RDY;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_WAIT_RDY: begin
                    if (ready_sel || timeout_hit) begin
                        // A timeout is flagged only when ready did not arrive on that same edge.
                        if (!ready_sel) begin
                            timeout_next = 1'b1;
                        end
                        cnt_next = '0;
                        if (last_stage) begin
                            done_next  = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            stage_next = stage_reg + STAGE_W'(1);
                            state_next = ST_DELAY;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_DELAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_DELAY;
            cnt_reg     <= '0;
            stage_reg   <= '0;
            rst_reg     <= {STAGES{OUT_POL}};
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            stage_reg   <= stage_next;
            rst_reg     <= rst_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.rst_o     = rst_reg;
    assign bus.stage_o   = stage_reg;
    assign bus.done_o    = done_reg;
    assign bus.timeout_o = timeout_reg;

endmodule

// File: doc/rst_release_sequencer.md
# rst_release_sequencer

Sits directly downstream of the reset synchronizer. It takes that block's synchronously-deasserted reset and releases `STAGES` subsystem resets one at a time, in index order. Each release waits for the previous stage to report ready, and a fixed settle delay separates consecutive releases. A timeout guards each ready wait, and a software re-sequence request replays the whole sequence.

## Interface
- `STAGES`, 4: number of sequenced reset outputs, ≥1.
- `DELAY`, 16: clk cycles from sequence start or previous ready to the next release, ≥1.
- `TIMEOUT`, 1024: max clk cycles spent waiting for a stage ready, ≥1.
- `OUT_POL`, 1'b1: asserted level of `rst_o` bits.
- `clk`  in  1  single clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low; driven by the upstream synchronizer output.
- `sw_rst_i`  in  1  synchronous re-sequence request, sampled every edge.
- `stage_ready_i`  in  STAGES  per-stage ready, synchronous to clk.
- `rst_o`  out  STAGES  per-stage reset, `OUT_POL` = held in reset.
- `stage_o`  out  $clog2(STAGES) (min 1)  index of the stage currently being sequenced.
- `done_o`  out  1  all stages released and ready.
- `timeout_o`  out  1  sticky: at least one stage timed out.

## Operation
- Reset values while `rst_n_i`=0 (asynchronous): `rst_o`={STAGES{OUT_POL}}, `stage_o`=0, `done_o`=0, `timeout_o`=0, counter=0, state=DELAY.
- States:
  - DELAY: counter increments each edge; on the edge where count reaches DELAY, deassert `rst_o[stage]`, clear counter, go to WAIT_RDY.
  - WAIT_RDY: `stage_ready_i[stage]`=1 ends the wait. Alternatively the counter reaches TIMEOUT without ready; that edge sets `timeout_o`=1 and is treated as ready. On ready: last stage → DONE with `done_o`=1; otherwise `stage`+1, counter cleared, go to DELAY.
  - DONE: hold; `rst_o` stays all deasserted.
- Ready is only sampled for the current stage in WAIT_RDY. Earlier or later ready bits are ignored.
- Released stages are never re-asserted except by `sw_rst_i` or `rst_n_i`.
- `sw_rst_i`=1 in any state: next edge sets all `rst_o` asserted, clears `stage_o`, counter, `done_o` and `timeout_o`, and enters DELAY. It has priority over any simultaneous ready, timeout or release.
- Single shared counter, width $clog2(max(DELAY,TIMEOUT)+1). The counter never wraps.

## Timing
- Edge 1 = first rising clk edge with `rst_n_i` high (or first edge after the `sw_rst_i` edge).
- `rst_o[0]` deasserts on edge DELAY.
- Ready seen at edge t → `rst_o[k+1]` deasserts at edge t+DELAY.
- Ready for the last stage seen at edge t → `done_o`=1 after edge t.
- Timeout: ready low for TIMEOUT consecutive WAIT_RDY edges → `timeout_o` set on the TIMEOUT-th edge; the next release follows DELAY edges later.
- All outputs are registered; nothing is combinational from inputs.
- `rst_n_i` assertion mid-sequence: outputs return to reset values immediately, with no clock required.

## Structure
- Shared package `rst_seq_pkg`:
  - state enum (DELAY, WAIT_RDY, DONE);
  - counter-width helper function.
- No sub-module; the counter and FSM stay inline.
- The top level instantiates the existing synchronizer upstream and feeds its output to `rst_n_i`.

## Test plan
All scenarios use STAGES=3, DELAY=4, TIMEOUT=8, OUT_POL=1.
- Ready tied high, release `rst_n_i` → `rst_o` 111→110 at edge 4, 100 at edge 9, 000 at edge 14; `done_o`=1 after edge 15; `timeout_o`=0.
- `stage_ready_i[1]` held low, others high → `rst_o[1]` deasserts at edge 9; `timeout_o`=1 at edge 17; `rst_o[2]` deasserts at edge 21; `done_o`=1 after edge 22.
- `sw_rst_i` pulse in DONE → `rst_o`=111, `done_o`=0 and `timeout_o`=0 on the next edge; `rst_o[0]` deasserts 4 edges later.
- `rst_n_i` driven low between clk edges after `rst_o[1]` release → `rst_o`=111 and `stage_o`=0 immediately, with no edge required.
- `sw_rst_i` on the same edge as last-stage ready → `done_o` stays 0 and `rst_o` returns to 111.
- `stage_ready_i[2]` high before stage 2 is released → ignored; `rst_o[2]` still deasserts only DELAY edges after stage-1 ready.
